// File: rtl/bch_pkg.sv
// Shared definitions for the DEC BCH streaming remainder engine:
// generator polynomials g(x) = m1(x)*m3(x) for m = 5..8, remainder width,
// and the frame mode encoding.
package bch_pkg;

  typedef enum logic {
    BCH_MODE_ENC = 1'b0,
    BCH_MODE_CHK = 1'b1
  } bch_mode_e;

  // Remainder width R = 2m (degree of the DEC generator polynomial).
  function automatic int fn_bch_rem_w(input int m);
    return 2 * m;
  endfunction

  // Full generator polynomial including the x^(2m) term.
  function automatic logic [16:0] fn_bch_dec_gpoly(input int m);
    logic [16:0] g;
    case (m)
      5:       g = 17'h00769;
      6:       g = 17'h01539;
      7:       g = 17'h04377;
      8:       g = 17'h16F63;
      default: g = 17'h00000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bch_dec_stream_lfsr_if.sv
// Beat/result bus of bch_dec_stream_lfsr.
// slave modport is the engine side, master modport the frame source/result sink.
// Optional BCH_FRAME_CHK_EN adds s_last_i and res_err_o.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A source holds valid, data and sideband stable until that
// edge; ready may be asserted independently of valid.
interface bch_dec_stream_lfsr_if #(
  parameter int P_BEAT_W = 4,
  parameter int P_REM_W  = 10
);
  logic                mode_i;
  logic                s_valid_i;
  logic                s_ready_o;
  logic [P_BEAT_W-1:0] s_data_i;
  logic                res_valid_o;
  logic                res_ready_i;
  logic [P_REM_W-1:0]  res_o;
  logic                res_zero_o;
  logic                res_mode_o;
`ifdef BCH_FRAME_CHK_EN
  logic                s_last_i;
  logic                res_err_o;

  modport slave (
    input  mode_i, s_valid_i, s_data_i, s_last_i, res_ready_i,
    output s_ready_o, res_valid_o, res_o, res_zero_o, res_mode_o, res_err_o
  );
  modport master (
    output mode_i, s_valid_i, s_data_i, s_last_i, res_ready_i,
    input  s_ready_o, res_valid_o, res_o, res_zero_o, res_mode_o, res_err_o
  );
`else
  modport slave (
    input  mode_i, s_valid_i, s_data_i, res_ready_i,
    output s_ready_o, res_valid_o, res_o, res_zero_o, res_mode_o
  );
  modport master (
    output mode_i, s_valid_i, s_data_i, res_ready_i,
    input  s_ready_o, res_valid_o, res_o, res_zero_o, res_mode_o
  );
`endif
endinterface

// File: rtl/bch_lfsr_step.sv
// Combinational unrolled division step: folds P_NBITS bits (MSB first) into
// the 2m-bit remainder, either as a parity encoder or as a syndrome divider.
module bch_lfsr_step
  import bch_pkg::*;
#(
  parameter bch_mode_e P_MODE  = BCH_MODE_ENC,
  parameter int        P_GF_M  = 5,
  parameter int        P_NBITS = 4
) (
  input  logic [2*P_GF_M-1:0]  r_i,
  input  logic [P_NBITS-1:0]   bits_i,
  output logic [2*P_GF_M-1:0]  r_o
);
  localparam int R = fn_bch_rem_w(P_GF_M);
  localparam logic [R-1:0] G = R'(fn_bch_dec_gpoly(P_GF_M));

  logic [R-1:0] acc;
  logic         fb;

  // Bit-serial division unrolled over the bits of one beat, earliest bit first.
  always_comb begin
    acc = r_i;
    fb  = 1'b0;
    for (int i = 0; i < P_NBITS; i++) begin
      if (P_MODE == BCH_MODE_ENC) begin
        fb  = bits_i[P_NBITS-1-i] ^ acc[R-1];
        acc = (acc << 1) ^ (fb ? G : '0);
      end else begin
        fb  = acc[R-1];
        acc = {acc[R-2:0], bits_i[P_NBITS-1-i]} ^ (fb ? G : '0);
      end
    end
    r_o = acc;
  end

endmodule

// File: rtl/bch_dec_stream_lfsr.sv
// Streaming DEC BCH parity/syndrome engine. Frames arrive as P_BEAT_W-bit
// beats (MSB first); the 2m-bit remainder is held until consumed.
// Optional feature macro: BCH_FRAME_CHK_EN (s_last_i framing and res_err_o).
module bch_dec_stream_lfsr
  import bch_pkg::*;
#(
  parameter int P_GF_M    = 5,
  parameter int P_D_WIDTH = 21,
  parameter int P_BEAT_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  bch_dec_stream_lfsr_if.slave  bus,
  output logic [0:0]            dbg_state_o
);
  localparam int R      = fn_bch_rem_w(P_GF_M);
  localparam int L_ENC  = P_D_WIDTH;
  localparam int L_CHK  = P_D_WIDTH + R;
  localparam int B_ENC  = (L_ENC + P_BEAT_W - 1) / P_BEAT_W;
  localparam int B_CHK  = (L_CHK + P_BEAT_W - 1) / P_BEAT_W;
  localparam int N_ENC  = L_ENC - (B_ENC - 1) * P_BEAT_W;
  localparam int N_CHK  = L_CHK - (B_CHK - 1) * P_BEAT_W;
  localparam int CNT_W  = $clog2(B_CHK + 1);
  localparam logic [CNT_W-1:0] LAST_ENC = CNT_W'(B_ENC - 1);
  localparam logic [CNT_W-1:0] LAST_CHK = CNT_W'(B_CHK - 1);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state;
  logic [R-1:0]     r;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;

  logic             accept;
  logic             pop;
  logic             cur_mode;
  logic             last_cnt;
  logic             close;
  logic [R-1:0]     r_next;
  logic [R-1:0]     r_enc_full, r_enc_last, r_chk_full, r_chk_last;

  bch_lfsr_step #(.P_MODE(BCH_MODE_ENC), .P_GF_M(P_GF_M), .P_NBITS(P_BEAT_W)) u_enc_full (
    .r_i(r), .bits_i(bus.s_data_i), .r_o(r_enc_full));
  bch_lfsr_step #(.P_MODE(BCH_MODE_ENC), .P_GF_M(P_GF_M), .P_NBITS(N_ENC)) u_enc_last (
    .r_i(r), .bits_i(bus.s_data_i[P_BEAT_W-1 -: N_ENC]), .r_o(r_enc_last));
  bch_lfsr_step #(.P_MODE(BCH_MODE_CHK), .P_GF_M(P_GF_M), .P_NBITS(P_BEAT_W)) u_chk_full (
    .r_i(r), .bits_i(bus.s_data_i), .r_o(r_chk_full));
  bch_lfsr_step #(.P_MODE(BCH_MODE_CHK), .P_GF_M(P_GF_M), .P_NBITS(N_CHK)) u_chk_last (
    .r_i(r), .bits_i(bus.s_data_i[P_BEAT_W-1 -: N_CHK]), .r_o(r_chk_last));

`ifdef BCH_FRAME_CHK_EN
  logic err_q;
  logic err_next;
`endif

  // Beat acceptance, mode selection (first beat samples mode_i) and next remainder.
  always_comb begin
    accept   = (state == ST_RUN) && bus.s_valid_i;
    pop      = (state == ST_HOLD) && bus.res_ready_i;
    cur_mode = (cnt == '0) ? bus.mode_i : mode_q;
    last_cnt = cur_mode ? (cnt == LAST_CHK) : (cnt == LAST_ENC);
    if (cur_mode) r_next = last_cnt ? r_chk_last : r_chk_full;
    else          r_next = last_cnt ? r_enc_last : r_enc_full;
`ifdef BCH_FRAME_CHK_EN
    close    = last_cnt || bus.s_last_i;
    err_next = last_cnt ? !bus.s_last_i : bus.s_last_i;
`else
    close    = last_cnt;
`endif
  end

  // RUN accumulates beats; HOLD presents the remainder until it is consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_RUN;
      r      <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
`ifdef BCH_FRAME_CHK_EN
      err_q  <= 1'b0;
`endif
    end else if (accept) begin
      r      <= r_next;
      mode_q <= cur_mode;
      if (close) begin
        state <= ST_HOLD;
`ifdef BCH_FRAME_CHK_EN
        err_q <= err_next;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (pop) begin
      state  <= ST_RUN;
      r      <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
`ifdef BCH_FRAME_CHK_EN
      err_q  <= 1'b0;
`endif
    end
  end

  // Result outputs read as their reset values outside HOLD.
  always_comb begin
    bus.s_ready_o   = (state == ST_RUN);
    bus.res_valid_o = (state == ST_HOLD);
    bus.res_o       = (state == ST_HOLD) ? r : '0;
    bus.res_zero_o  = (bus.res_o == '0);
    bus.res_mode_o  = (state == ST_HOLD) && mode_q;
`ifdef BCH_FRAME_CHK_EN
    bus.res_err_o   = (state == ST_HOLD) && err_q;
`endif
    dbg_state_o     = state;
  end

endmodule
